qspi_rx_packer: RTL and testbench
=================================

Name: qspi_rx_packer

Overview:
Sits between the QSPI receive shift engine and the RX FIFO. Accepts one received byte at a time and packs bytes little-endian (first byte in bits [7:0]) into WIDTH-bit words. Pushes each complete word into the FIFO write port. At end of transfer, flushes any partial word zero-filled. Flags bytes lost to FIFO backpressure.

Parameters:
WIDTH, 32, packed word width; multiple of 8, >= 16; must match the RX FIFO WIDTH
NB, WIDTH/8, bytes per word (localparam, derived)

Ports:
clk  input  1  clock
resetn  input  1  reset, asynchronous, active-low
start_i  input  1  one-cycle pulse at transfer start; aborts and clears any partial or pending word
byte_valid_i  input  1  byte strobe from shift engine
byte_data_i  input  8  received byte
last_i  input  1  qualifies byte_valid_i; marks final byte of transfer
byte_ready_o  output  1  packer can take a byte this cycle
fifo_full_i  input  1  RX FIFO full
fifo_wr_en_o  output  1  FIFO write strobe
fifo_wr_data_o  output  WIDTH  FIFO write data
overflow_o  output  1  sticky; a byte was dropped
clr_ovf_i  input  1  synchronous clear of overflow_o
busy_o  output  1  state != IDLE
done_o  output  1  one-cycle pulse when the final word of a transfer is written
rx_count_o  output  16  bytes accepted since last start_i; saturates at 16'hFFFF

Behaviour:
- Reset values: state IDLE, accumulator 0, byte index 0, fifo_wr_data_o 0, overflow_o 0, done_o 0, rx_count_o 0.
- States:
  - IDLE: no data held.
  - COLLECT: 1..NB-1 bytes held.
  - PUSH: word in fifo_wr_data_o awaiting FIFO space.
- byte_ready_o = (state != PUSH) || start_i.
- Byte accept = byte_valid_i && byte_ready_o.
  - Accepted byte is written to accumulator lane [8*idx +: 8].
  - Index increments.
  - rx_count_o increments, saturating.
- Word completion: accepted byte with idx == NB-1, or with last_i = 1.
  - Next cycle: state = PUSH.
  - fifo_wr_data_o = accumulator including the new byte, unused upper lanes 0.
  - Index and accumulator clear.
  - An internal last flag records last_i.
- Non-completing accept: IDLE -> COLLECT; stays in COLLECT.
- fifo_wr_en_o = (state == PUSH) && !fifo_full_i. Combinational from registered state and fifo_full_i.
- Write timing: word completed at cycle t gives fifo_wr_en_o high at t+1 if FIFO not full. Otherwise it holds, with fifo_wr_data_o stable, until the first non-full cycle.
- On a PUSH cycle with fifo_wr_en_o high:
  - If the last flag is set: next state IDLE, done_o = 1 the next cycle.
  - Else: next state IDLE (nothing held).
- Throughput: one byte per 2 clk when FIFO never full. The shift engine guarantees byte spacing >= 2 clk.
- Drop: byte_valid_i && !byte_ready_o.
  - Byte discarded; overflow_o set the next cycle.
  - rx_count_o unchanged; pending word unaffected.
  - If the dropped byte carried last_i, the pending word does not become last.
- overflow_o: clr_ovf_i clears it. A set in the same cycle as clr_ovf_i wins.
- start_i (highest priority):
  - Clears accumulator, index, pending word, last flag and rx_count_o.
  - State becomes IDLE; no FIFO write that cycle.
  - A coincident byte_valid_i is accepted as byte 0 of the new transfer: rx_count_o = 1, state COLLECT, or PUSH if NB = 1 or last_i.
  - overflow_o is not cleared by start_i.
- last_i with no bytes held: not possible except with a byte; a lone last byte yields a word of {0.., byte}.
- Asynchronous reset mid-transfer: all state lost immediately; no write issued.

Test Plan:
1. Bytes 11,22,33,44 (2-clk spacing, FIFO empty) -> one write, fifo_wr_data_o = 32'h44332211 one cycle after byte 44; rx_count_o = 4; no done_o.
2. Bytes AA,BB,CC with last_i on CC -> write 32'h00CCBBAA; done_o pulses one cycle after the write; busy_o returns 0.
3. fifo_full_i held high across completion of 32'h04030201 for 5 cycles -> no write, data stable, byte_ready_o = 0; write on first cycle full drops; a byte sent while held -> overflow_o = 1, rx_count_o stays 4.
4. clr_ovf_i pulse -> overflow_o = 0; clr_ovf_i coincident with a new drop -> overflow_o stays 1.
5. Two bytes held, then start_i with coincident byte 5A -> no write of the old data; rx_count_o = 1; next 3 bytes 01,02,03 give 32'h0302015A.
6. 70000 bytes without start_i -> rx_count_o saturates at 16'hFFFF; 17500 writes issued; resetn asserted mid-word -> all outputs return to reset values without a write.

Source files
------------

// File: rtl/qspi_rx_packer.sv
// QSPI receive packer: gathers bytes little-endian into WIDTH-bit
// words and pushes them to the RX FIFO, flagging bytes lost to backpressure.
module qspi_rx_packer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  input  logic             last_i,
  output logic             byte_ready_o,
  input  logic             fifo_full_i,
  output logic             fifo_wr_en_o,
  output logic [WIDTH-1:0] fifo_wr_data_o,
  output logic             overflow_o,
  input  logic             clr_ovf_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      rx_count_o
);

  localparam int NB = WIDTH / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_PUSH
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_wdata;
  logic             r_last;
  logic             r_ovf;
  logic             r_done;
  logic [15:0]      r_cnt;

  logic             w_ready;
  logic             w_accept;
  logic             w_drop;
  logic             w_wr;
  logic             w_complete;
  logic [WIDTH-1:0] w_base_acc;
  logic [IW-1:0]    w_base_idx;
  logic [15:0]      w_base_cnt;
  logic [WIDTH-1:0] w_merged;

  // Handshake decode: a start always makes room for a fresh byte.
  always_comb begin
    w_ready  = (r_state != S_PUSH) || start_i;
    w_accept = byte_valid_i && w_ready;
    w_drop   = byte_valid_i && !w_ready;
    w_wr     = (r_state == S_PUSH) && !fifo_full_i && !start_i;
  end

  // Merge the incoming byte into the (possibly start-cleared) accumulator.
  always_comb begin
    w_base_acc = start_i ? '0 : r_acc;
    w_base_idx = start_i ? '0 : r_idx;
    w_base_cnt = start_i ? '0 : r_cnt;
    w_merged   = w_base_acc;
    for (int k = 0; k < NB; k++) begin
      if (w_base_idx == IW'(k)) begin
        w_merged[8*k +: 8] = byte_data_i;
      end
    end
    w_complete = w_accept &&
                 ((w_base_idx == IW'(NB - 1)) || last_i);
  end

  // Next-state selection; start aborts, an accepted byte overrides.
  always_comb begin
    w_state_nxt = r_state;
    if (w_wr) begin
      w_state_nxt = S_IDLE;
    end
    if (start_i) begin
      w_state_nxt = S_IDLE;
    end
    if (w_accept) begin
      w_state_nxt = w_complete ? S_PUSH : S_COLLECT;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Accumulator, lane index, pending word and its last flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_last  <= 1'b0;
    end else begin
      if (start_i) begin
        r_acc   <= '0;
        r_idx   <= '0;
        r_wdata <= '0;
        r_last  <= 1'b0;
      end
      if (w_accept) begin
        if (w_complete) begin
          r_wdata <= w_merged;
          r_acc   <= '0;
          r_idx   <= '0;
          r_last  <= last_i;
        end else begin
          r_acc <= w_merged;
          r_idx <= w_base_idx + 1'b1;
        end
      end
    end
  end

  // Saturating count of bytes accepted since the last start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= (w_base_cnt == 16'hFFFF) ? 16'hFFFF
                                        : w_base_cnt + 16'd1;
    end else if (start_i) begin
      r_cnt <= '0;
    end
  end

  // Sticky overflow (a new drop beats clear) and end-of-transfer pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf_i) begin
        r_ovf <= 1'b0;
      end
      r_done <= w_wr && r_last;
    end
  end

  assign byte_ready_o   = w_ready;
  assign fifo_wr_en_o   = w_wr;
  assign fifo_wr_data_o = r_wdata;
  assign overflow_o     = r_ovf;
  assign busy_o         = (r_state != S_IDLE);
  assign done_o         = r_done;
  assign rx_count_o     = r_cnt;

endmodule

// File: tb/tb_qspi_rx_packer.sv
// Directed bench for qspi_rx_packer.
// Drives 1 time unit after each rising edge and checks there.
module tb_qspi_rx_packer;

  logic        clk;
  logic        resetn;
  logic        start_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        last_i;
  logic        byte_ready_o;
  logic        fifo_full_i;
  logic        fifo_wr_en_o;
  logic [31:0] fifo_wr_data_o;
  logic        overflow_o;
  logic        clr_ovf_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] rx_count_o;

  int nerr;
  int nchk;
  int nwr;
  int wr0;

  qspi_rx_packer #(.WIDTH(32)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .start_i        (start_i),
    .byte_valid_i   (byte_valid_i),
    .byte_data_i    (byte_data_i),
    .last_i         (last_i),
    .byte_ready_o   (byte_ready_o),
    .fifo_full_i    (fifo_full_i),
    .fifo_wr_en_o   (fifo_wr_en_o),
    .fifo_wr_data_o (fifo_wr_data_o),
    .overflow_o     (overflow_o),
    .clr_ovf_i      (clr_ovf_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .rx_count_o     (rx_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (resetn && fifo_wr_en_o) nwr++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    byte_valid_i = 1'b1;
    byte_data_i  = d;
    last_i       = l;
    tick();
    byte_valid_i = 1'b0;
    last_i       = 1'b0;
  endtask

  task automatic send_g(input logic [7:0] d, input logic l);
    send(d, l);
    tick();
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    nerr = 0;
    nchk = 0;
    nwr  = 0;
    resetn       = 1'b0;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    last_i       = 1'b0;
    fifo_full_i  = 1'b0;
    clr_ovf_i    = 1'b0;
    #12;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_data", fifo_wr_data_o, 32'h0);
    chk("rst_cnt", 32'(rx_count_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_wren", 32'(fifo_wr_en_o), 32'd0);
    resetn = 1'b1;
    tick();

    // 1: full word
    send_g(8'h11, 1'b0);
    send_g(8'h22, 1'b0);
    send_g(8'h33, 1'b0);
    chk("t1_cnt3", 32'(rx_count_o), 32'd3);
    send(8'h44, 1'b0);
    chk("t1_wren", 32'(fifo_wr_en_o), 32'd1);
    chk("t1_data", fifo_wr_data_o, 32'h44332211);
    chk("t1_cnt", 32'(rx_count_o), 32'd4);
    tick();
    chk("t1_done", 32'(done_o), 32'd0);
    chk("t1_busy", 32'(busy_o), 32'd0);
    chk("t1_nwr", 32'(nwr), 32'd1);

    // 2: short last word
    pulse_start();
    chk("t2_cnt0", 32'(rx_count_o), 32'd0);
    send_g(8'hAA, 1'b0);
    send_g(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    chk("t2_wren", 32'(fifo_wr_en_o), 32'd1);
    chk("t2_data", fifo_wr_data_o, 32'h00CCBBAA);
    chk("t2_done0", 32'(done_o), 32'd0);
    tick();
    chk("t2_done", 32'(done_o), 32'd1);
    chk("t2_busy", 32'(busy_o), 32'd0);
    tick();
    chk("t2_done_end", 32'(done_o), 32'd0);

    // 3: backpressure
    pulse_start();
    fifo_full_i = 1'b1;
    send_g(8'h01, 1'b0);
    send_g(8'h02, 1'b0);
    send_g(8'h03, 1'b0);
    send(8'h04, 1'b0);
    wr0 = nwr;
    chk("t3_wren", 32'(fifo_wr_en_o), 32'd0);
    chk("t3_rdy", 32'(byte_ready_o), 32'd0);
    chk("t3_ovf0", 32'(overflow_o), 32'd0);
    tick();
    send(8'h99, 1'b1);
    chk("t3_ovf", 32'(overflow_o), 32'd1);
    chk("t3_cnt", 32'(rx_count_o), 32'd4);
    tick();
    tick();
    chk("t3_hold", fifo_wr_data_o, 32'h04030201);
    chk("t3_nowr", 32'(nwr - wr0), 32'd0);
    fifo_full_i = 1'b0;
    #1;
    chk("t3_wren1", 32'(fifo_wr_en_o), 32'd1);
    chk("t3_data", fifo_wr_data_o, 32'h04030201);
    tick();
    chk("t3_nwr", 32'(nwr - wr0), 32'd1);
    chk("t3_idle", 32'(busy_o), 32'd0);
    chk("t3_nodone", 32'(done_o), 32'd0);

    // 4: overflow clear vs new drop
    clr_ovf_i = 1'b1;
    tick();
    clr_ovf_i = 1'b0;
    chk("t4_clr", 32'(overflow_o), 32'd0);
    fifo_full_i = 1'b1;
    send_g(8'h05, 1'b0);
    send_g(8'h06, 1'b0);
    send_g(8'h07, 1'b0);
    send(8'h08, 1'b0);
    clr_ovf_i = 1'b1;
    send(8'h09, 1'b0);
    clr_ovf_i = 1'b0;
    chk("t4_setwins", 32'(overflow_o), 32'd1);
    fifo_full_i = 1'b0;
    tick();
    clr_ovf_i = 1'b1;
    tick();
    clr_ovf_i = 1'b0;
    chk("t4_clr2", 32'(overflow_o), 32'd0);

    // 5: restart mid-word with coincident byte
    pulse_start();
    send_g(8'hE1, 1'b0);
    send_g(8'hE2, 1'b0);
    wr0 = nwr;
    start_i = 1'b1;
    send(8'h5A, 1'b0);
    start_i = 1'b0;
    chk("t5_cnt", 32'(rx_count_o), 32'd1);
    chk("t5_busy", 32'(busy_o), 32'd1);
    tick();
    send_g(8'h01, 1'b0);
    send_g(8'h02, 1'b0);
    send(8'h03, 1'b0);
    chk("t5_wren", 32'(fifo_wr_en_o), 32'd1);
    chk("t5_data", fifo_wr_data_o, 32'h0302015A);
    tick();
    chk("t5_nwr", 32'(nwr - wr0), 32'd1);

    // 6: count saturation, then reset mid-word
    pulse_start();
    wr0 = nwr;
    for (int w = 0; w < 16384; w++) begin
      if (w == 16383) chk("t6_cnt_pre", 32'(rx_count_o), 32'h0000FFFC);
      byte_valid_i = 1'b1;
      for (int b = 0; b < 4; b++) begin
        byte_data_i = 8'(w + b);
        tick();
      end
      byte_valid_i = 1'b0;
      tick();
    end
    chk("t6_sat", 32'(rx_count_o), 32'h0000FFFF);
    chk("t6_nwr", 32'(nwr - wr0), 32'd16384);
    send_g(8'h77, 1'b0);
    chk("t6_sat2", 32'(rx_count_o), 32'h0000FFFF);
    send(8'h78, 1'b0);
    wr0 = nwr;
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_r_busy", 32'(busy_o), 32'd0);
    chk("t6_r_cnt", 32'(rx_count_o), 32'd0);
    chk("t6_r_data", fifo_wr_data_o, 32'h0);
    chk("t6_r_wren", 32'(fifo_wr_en_o), 32'd0);
    tick();
    tick();
    chk("t6_r_nowr", 32'(nwr - wr0), 32'd0);
    resetn = 1'b1;
    tick();
    send(8'hF0, 1'b1);
    chk("t6_post", fifo_wr_data_o, 32'h000000F0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
